// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Constants shared by the binarized fully-connected neuron and its output
// packer: vector geometry, sum/activation widths, the requantization shift and
// the signed activation range. Also holds the packer's handshake state type,
// encoded as {asm_full, vec_valid} so the state bits drive those outputs directly.
// -----------------------------------------------------------------------------
package fc_pkg;

    localparam int LANES   = 32;                       // activations per vector
    localparam int SUM_W   = 9;                        // signed neuron sum width
    localparam int ACT_W   = 4;                        // signed activation width
    localparam int SHIFT   = 2;                        // arithmetic right shift
    localparam int ACT_MAX = (1 << (ACT_W - 1)) - 1;   // +7
    localparam int ACT_MIN = -(1 << (ACT_W - 1));      // -8
    localparam int VEC_W   = LANES * ACT_W;            // packed vector width
    localparam int LANE_W  = $clog2(LANES);            // lane counter width

    // {asm_full, vec_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_OUT   = 2'b01,
        ST_STALL = 2'b11
    } pack_state_t;

endpackage

// File: rtl/fc_act_packer_if.sv
// -----------------------------------------------------------------------------
// fc_act_packer_if
// Sample input and packed-vector output of the activation packer.
//   sum_in/sum_valid : one signed neuron sum per valid cycle (producer -> packer)
//   vec_out/vec_valid: packed activation vector offered downstream
//   vec_ready        : consumer accepts when vec_valid && vec_ready
// master = the neuron/consumer side, slave = the packer.
// -----------------------------------------------------------------------------
interface fc_act_packer_if #(
    parameter int SUM_W = fc_pkg::SUM_W,
    parameter int VEC_W = fc_pkg::VEC_W
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic [VEC_W-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready;

    modport master (output sum_in, sum_valid, vec_ready, input vec_out, vec_valid);
    modport slave  (input sum_in, sum_valid, vec_ready, output vec_out, vec_valid);
endinterface

// File: rtl/act_quant.sv
// -----------------------------------------------------------------------------
// act_quant
// Combinational requantizer: arithmetic right shift (floor toward -inf) of a
// signed sum, then saturation to the signed activation range.
//   sum_in : signed SUM_W-bit neuron sum
//   act    : ACT_W-bit two's-complement activation
// -----------------------------------------------------------------------------
module act_quant #(
    parameter int SUM_W   = fc_pkg::SUM_W,
    parameter int ACT_W   = fc_pkg::ACT_W,
    parameter int SHIFT   = fc_pkg::SHIFT,
    parameter int ACT_MAX = fc_pkg::ACT_MAX,
    parameter int ACT_MIN = fc_pkg::ACT_MIN
) (
    input  logic signed [SUM_W-1:0] sum_in,
    output logic        [ACT_W-1:0] act
);
    logic signed [SUM_W-1:0] shifted;

    always_comb begin
        shifted = sum_in >>> SHIFT;
        // int'() of a signed operand sign-extends, so these are true signed compares.
        if (int'(shifted) > ACT_MAX) begin
            act = ACT_W'(ACT_MAX);
        end else if (int'(shifted) < ACT_MIN) begin
            act = ACT_W'(ACT_MIN);
        end else begin
            act = shifted[ACT_W-1:0];
        end
    end
endmodule

// File: rtl/fc_act_packer.sv
// -----------------------------------------------------------------------------
// fc_act_packer
// Requantizes neuron sums to activations and packs LANES of them, lane 0 in the
// top nibble, into a vector offered on a valid/ready handshake. An assembly
// buffer and an output register give double buffering: a full vector waits in
// the assembly buffer (asm_full) while the output register is still unaccepted.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : sum_in/sum_valid in, vec_out/vec_valid out, vec_ready in
//   clear       : drop partial/held assembly and the overflow flag
//   lane_count  : lanes filled in the assembly buffer
//   asm_full    : complete vector held, waiting for the output register
//   overflow    : sticky, a sample arrived while asm_full was set
// -----------------------------------------------------------------------------
module fc_act_packer #(
    parameter int LANES = fc_pkg::LANES,
    parameter int SUM_W = fc_pkg::SUM_W,
    parameter int ACT_W = fc_pkg::ACT_W,
    parameter int SHIFT = fc_pkg::SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    fc_act_packer_if.slave           bus,
    input  logic                     clear,
    output logic [$clog2(LANES)-1:0] lane_count,
    output logic                     asm_full,
    output logic                     overflow
);
    import fc_pkg::*;

    localparam int VW = LANES * ACT_W;
    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    pack_state_t   state, state_next;
    logic [ACT_W-1:0] act;
    logic [VW-1:0] asm_buf, asm_merged, vec_q;
    logic          accept, complete, load_out;

    act_quant #(
        .SUM_W (SUM_W),
        .ACT_W (ACT_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .sum_in (bus.sum_in),
        .act    (act)
    );

    // clear outranks sum_valid; a held vector blocks new samples.
    assign accept   = bus.sum_valid && (state != ST_STALL) && !clear;
    assign complete = accept && (lane_count == LAST_LANE);

    // Assembly buffer with the incoming lane already inserted, so the 32nd
    // sample can go straight to the output register in the same cycle.
    always_comb begin
        asm_merged = asm_buf;
        asm_merged[(LANES - 1 - int'(lane_count)) * ACT_W +: ACT_W] = act;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        state_next = state;
        load_out   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (complete) begin
                    state_next = ST_OUT;
                    load_out   = 1'b1;
                end
            end
            ST_OUT: begin
                if (complete) begin
                    load_out   = bus.vec_ready;
                    state_next = bus.vec_ready ? ST_OUT : ST_STALL;
                end else if (bus.vec_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_STALL: begin
                // clear discards the held vector; the output register is untouched.
                if (clear) begin
                    state_next = bus.vec_ready ? ST_EMPTY : ST_OUT;
                end else if (bus.vec_ready) begin
                    state_next = ST_OUT;
                    load_out   = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the vector buffers are plain registers, not RAM, and their reset value is observable, so they are reset too.
            state      <= ST_EMPTY;
            asm_buf    <= '0;
            vec_q      <= '0;
            lane_count <= '0;
            overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state <= state_next;
            if (load_out) begin
                vec_q <= (state == ST_STALL) ? asm_buf : asm_merged;
            end
            if (clear) begin
                asm_buf    <= '0;
                lane_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (accept) begin
                    asm_buf    <= asm_merged;
                    lane_count <= complete ? '0 : lane_count + 1'b1;
                end
                if (bus.sum_valid && state == ST_STALL) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.vec_valid = state[0];
    assign asm_full      = state[1];

endmodule
